// File: rtl/rca_4bit.sv
// rtl/rca_4bit.sv - registered 4-bit ripple-carry adder built from four full-adder stages
// Sum and carry-out are captured every rising clk edge; rst clears them asynchronously.

module rca_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic co
);
    logic p;

    assign p   = a ^ b;
    assign sum = p ^ ci;
    assign co  = (a & b) | (ci & p);
endmodule

module rca_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);
    logic [4:0] carry;
    logic [3:0] sum_w;
    logic [3:0] s_d;
    logic [3:0] s_q;
    logic       c_out_d;
    logic       c_out_q;

    assign carry[0] = c_in;

    // Each stage consumes the carry produced by the stage below it.
    for (genvar i = 0; i < 4; i++) begin : g_stage
        rca_full_adder u_fa (
            .a   (x[i]),
            .b   (y[i]),
            .ci  (carry[i]),
            .sum (sum_w[i]),
            .co  (carry[i+1])
        );
    end

    always_comb begin
        s_d     = sum_w;
        c_out_d = carry[4];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q     <= 4'h0;
            c_out_q <= 1'b0;
        end else begin
            s_q     <= s_d;
            c_out_q <= c_out_d;
        end
    end

    assign s     = s_q;
    assign c_out = c_out_q;
endmodule

// File: tb/tb_rca_4bit.sv
// tb/tb_rca_4bit.sv - self-checking bench for rca_4bit
// Arithmetic model plus directed literal expectations.

module tb_rca_4bit;
    logic       clk;
    logic       rst;
    logic [3:0] x;
    logic [3:0] y;
    logic       c_in;
    logic [3:0] s;
    logic       c_out;

    int checks;
    int errors;

    logic [4:0] model_q;
    int         edges_since_rst;

    rca_4bit dut (
        .clk   (clk),
        .rst   (rst),
        .x     (x),
        .y     (y),
        .c_in  (c_in),
        .s     (s),
        .c_out (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at %0t", name, got, got, exp, exp, $time);
        end
    endtask

    // Reference: the value present at each edge, summed as plain integers.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_q         = 5'd0;
            edges_since_rst = 0;
        end else begin
            model_q = 5'(int'(x) + int'(y) + int'(c_in));
            if (edges_since_rst < 3) edges_since_rst++;
        end
    end

    always @(negedge clk) begin
        if (rst)
            check("reset_hold", {c_out, s}, 5'd0);
        else if (edges_since_rst >= 2)
            check("model_cycle", {c_out, s}, model_q);
    end

    task automatic apply_and_check(input string name, input logic [3:0] xa, input logic [3:0] ya,
                                   input logic ci, input logic [4:0] lit);
        @(posedge clk);
        #2;
        x    = xa;
        y    = ya;
        c_in = ci;
        @(posedge clk);
        #1;
        check(name, {c_out, s}, lit);
        check({name, "_model"}, model_q, lit);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        x      = 4'd0;
        y      = 4'd0;
        c_in   = 1'b0;

        @(posedge clk);
        #3;
        check("reset_state", {c_out, s}, 5'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        apply_and_check("basic_5p6",      4'd5,  4'd6,  1'b0, 5'd11);
        apply_and_check("cin_only",       4'd0,  4'd0,  1'b1, 5'd1);
        apply_and_check("ripple_f_cin",   4'hF,  4'd0,  1'b1, 5'd16);
        apply_and_check("max_operands",   4'hF,  4'hF,  1'b1, 5'd31);
        apply_and_check("f_plus_1",       4'hF,  4'd1,  1'b0, 5'd16);

        // Latency: mid-cycle changes are invisible until the next edge, last one wins.
        @(posedge clk);
        #2;
        x = 4'd1; y = 4'd2; c_in = 1'b0;
        #1;
        check("latency_hold_a", {c_out, s}, 5'd16);
        #4;
        x = 4'd3; y = 4'd4;
        #1;
        check("latency_hold_b", {c_out, s}, 5'd16);
        @(posedge clk);
        #1;
        check("latency_last_wins", {c_out, s}, 5'd7);

        // Async reset between edges while holding 11.
        apply_and_check("pre_reset_11", 4'd5, 4'd6, 1'b0, 5'd11);
        #2;
        rst = 1'b1;
        #1;
        check("async_clear", {c_out, s}, 5'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_across_edges", {c_out, s}, 5'd0);
        x = 4'd9; y = 4'd4; c_in = 1'b1;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("release_first_edge", {c_out, s}, 5'd14);

        // Exhaustive sweep, one vector per cycle.
        for (int i = 0; i < 512; i++) begin
            @(posedge clk);
            #2;
            x    = 4'(i[3:0]);
            y    = 4'(i[7:4]);
            c_in = i[8];
        end
        @(posedge clk);
        #1;
        check("sweep_last", {c_out, s}, 5'd31);
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end
endmodule
